match_sequencer: RTL and testbench
==================================

# match_sequencer

Clocked match controller for the pong game. It steps the game through menu, court set-up, serve, rally, point and game-over phases. It keeps both players' scores and decides serve direction. It drives the ball datapath's hold/run controls. It sits between the debounced button/edge-detector inputs and the ball/paddle datapath, and its state code feeds the display mux.

## Interface
Parameters:
- WIN_SCORE, 5, points needed to win; must be in 1 .. 2^SCORE_W-1
- SCORE_W, 4, score counter width
- POINT_HOLD, 60, frame ticks spent in POINT before leaving; minimum 1
- SERVE_DELAY, 90, frame ticks before auto-serve (used only with AUTO_SERVE_EN)
- CNT_W, 8, tick counter width; must hold max(POINT_HOLD, SERVE_DELAY)

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- tick  in  1  one-cycle frame strobe; gates all hold/delay counting
- launch  in  1  debounced launch button level
- left_hit  in  1  ball crossed left goal line (right player scores)
- right_hit  in  1  ball crossed right goal line (left player scores)
- state  out  3  MENU=0, SET=1, SERVE=2, PLAY=3, POINT=4, OVER=5
- ball_reset  out  1  hold ball at centre; high in MENU, SET, SERVE, OVER
- ball_run  out  1  ball motion enable; high only in PLAY
- serve_dir  out  1  0 = serve toward left, 1 = toward right
- score_l  out  SCORE_W  left player score
- score_r  out  SCORE_W  right player score
- winner  out  1  0 = left, 1 = right; valid only in OVER

## Operation
- Launch event (`lrel`): prev_launch=1 and launch=0, i.e. button release. prev_launch is registered every cycle and resets to 0.
- MENU: on lrel, clear scores, set serve_dir=1, go to SET.
- SET: on lrel, go to SERVE.
- SERVE: clear tick counter on entry. On lrel, go to PLAY.
- PLAY:
  - left_hit only: increment score_r, set serve_dir=0, go to POINT.
  - right_hit only: increment score_l, set serve_dir=1, go to POINT.
  - Both in the same cycle: no score change, serve_dir unchanged, go to POINT.
- POINT: count ticks. On the tick where the count reaches POINT_HOLD-1:
  - go to OVER if either score equals WIN_SCORE;
  - otherwise go to SERVE.
- OVER: winner = (score_r == WIN_SCORE). On lrel, go to MENU. Scores are held until the MENU exit.
- left_hit and right_hit are ignored outside PLAY. lrel is ignored in PLAY and POINT.
- Scores saturate at WIN_SCORE and never wrap.
- Undefined state codes 6 and 7 go to MENU on the next clock.

## Timing
- Reset values: state=0, ball_reset=1, ball_run=0, serve_dir=1, scores=0, winner=0, tick counter=0, prev_launch=0.
- Reset has priority over every other input in the same cycle. It aborts any phase, including PLAY mid-rally and POINT mid-hold.
- Registers:
  - state, scores, serve_dir and winner are registered.
  - ball_reset and ball_run are decoded from the state register only; there is no combinational path from any input to any output.
- Latencies:
  - An input sampled at edge N takes effect on the outputs after edge N (one-cycle latency).
  - launch held high through reset release is not an event until it is seen high for one cycle and then low.
  - A hit in the last PLAY cycle scores; a hit in the first POINT cycle does not.
  - POINT lasts exactly POINT_HOLD tick strobes. The exit edge is the one that samples the POINT_HOLD-th tick.

## Configuration
- AUTO_SERVE_EN defined: SERVE also exits to PLAY on the tick where the counter reaches SERVE_DELAY-1. An lrel before that still serves immediately.
- AUTO_SERVE_EN undefined: SERVE waits for lrel only, SERVE_DELAY is unused, and the counter is idle in SERVE.

## Test plan
- Reset, launch released twice, released again → state 0→1→2→3; ball_run=1 one cycle after the third release; scores 0/0.
- In PLAY, pulse left_hit one cycle → next cycle state=4, score_r=1, serve_dir=0; after 60 ticks state=2, ball_reset=1.
- In PLAY, left_hit and right_hit in the same cycle → state=4, scores unchanged, serve_dir unchanged.
- Five right_hit points to the left player (WIN_SCORE=5) → after the fifth POINT hold state=5, winner=0, score_l=5. Extra hits keep score_l=5. A launch release returns state=0, and leaving MENU clears the scores.
- Assert reset mid-PLAY and mid-POINT → next cycle all outputs at reset values. With launch held through reset, the first release yields state=1 only if launch was high one cycle after reset.
- With AUTO_SERVE_EN and SERVE_DELAY=90: in SERVE with no launch, state=3 after the 90th tick. Without the macro, state stays 2 indefinitely.

Source files
------------

// File: rtl/match_sequencer.sv
// ============================================================================
// Module   : match_sequencer
// Brief    : Pong match controller: phases, scores, serve direction, ball hold/run.
//            Optional AUTO_SERVE_EN: SERVE also leaves on its own after SERVE_DELAY ticks.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module match_sequencer #(
    parameter int WIN_SCORE   = 5,
    parameter int SCORE_W     = 4,
    parameter int POINT_HOLD  = 60,
    parameter int SERVE_DELAY = 90,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               launch,
    input  logic               left_hit,
    input  logic               right_hit,
    output logic [2:0]         state,
    output logic               ball_reset,
    output logic               ball_run,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               winner
);

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_SET   = 3'd1,
        ST_SERVE = 3'd2,
        ST_PLAY  = 3'd3,
        ST_POINT = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_HOLD - 1);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY - 1);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               prev_launch_q;
    logic               lrel;

`ifndef AUTO_SERVE_EN
    logic unused_serve_last;
    assign unused_serve_last = ^SERVE_LAST;
`endif

    // A launch event is the button release, not the press.
    assign lrel = prev_launch_q & ~launch;

    always_comb begin
        state_d     = state_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_MENU: begin
                if (lrel) begin
                    score_l_d   = '0;
                    score_r_d   = '0;
                    serve_dir_d = 1'b1;
                    state_d     = ST_SET;
                end
            end
            ST_SET: begin
                if (lrel) begin
                    cnt_d   = '0;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (lrel) begin
                    state_d = ST_PLAY;
                end
`ifdef AUTO_SERVE_EN
                else if (tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
            ST_PLAY: begin
                if (left_hit || right_hit) begin
                    cnt_d   = '0;
                    state_d = ST_POINT;
                end
                if (left_hit && !right_hit) begin
                    if (score_r_q != WIN_VAL) score_r_d = score_r_q + 1'b1;
                    serve_dir_d = 1'b0;
                end else if (right_hit && !left_hit) begin
                    if (score_l_q != WIN_VAL) score_l_d = score_l_q + 1'b1;
                    serve_dir_d = 1'b1;
                end
            end
            ST_POINT: begin
                if (tick) begin
                    if (cnt_q == POINT_LAST) begin
                        cnt_d = '0;
                        if (score_l_q == WIN_VAL || score_r_q == WIN_VAL) begin
                            winner_d = (score_r_q == WIN_VAL);
                            state_d  = ST_OVER;
                        end else begin
                            state_d = ST_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (lrel) begin
                    state_d = ST_MENU;
                end
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_MENU;
            score_l_q     <= '0;
            score_r_q     <= '0;
            serve_dir_q   <= 1'b1;
            winner_q      <= 1'b0;
            cnt_q         <= '0;
            prev_launch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            cnt_q         <= cnt_d;
            prev_launch_q <= launch;
        end
    end

    // Ball controls decode from the state register only; codes 6/7 hold the ball.
    assign state      = state_q;
    assign ball_run   = (state_q == ST_PLAY);
    assign ball_reset = !((state_q == ST_PLAY) || (state_q == ST_POINT));
    assign serve_dir  = serve_dir_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign winner     = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_match_sequencer.sv
// ============================================================================
// Module   : tb_match_sequencer
// Brief    : Directed self-checking bench for match_sequencer (default parameters).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_match_sequencer;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       launch;
    logic       left_hit;
    logic       right_hit;
    logic [2:0] state;
    logic       ball_reset;
    logic       ball_run;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       winner;

    int checks = 0;
    int errors = 0;

    match_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .launch     (launch),
        .left_hit   (left_hit),
        .right_hit  (right_hit),
        .state      (state),
        .ball_reset (ball_reset),
        .ball_run   (ball_run),
        .serve_dir  (serve_dir),
        .score_l    (score_l),
        .score_r    (score_r),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_launch();
        launch = 1'b1;
        step();
        launch = 1'b0;
        step();
    endtask

    task automatic hold_point();
        tick = 1'b1;
        repeat (60) step();
        tick = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_state"}, int'(state), 0);
        check_eq({tag, "_ball_reset"}, int'(ball_reset), 1);
        check_eq({tag, "_ball_run"}, int'(ball_run), 0);
        check_eq({tag, "_serve_dir"}, int'(serve_dir), 1);
        check_eq({tag, "_score_l"}, int'(score_l), 0);
        check_eq({tag, "_score_r"}, int'(score_r), 0);
        check_eq({tag, "_winner"}, int'(winner), 0);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; launch = 1'b0; left_hit = 1'b0; right_hit = 1'b0;
        #1;
        step(); step();
        reset = 1'b0;
        check_reset_outputs("rst");

        // MENU -> SET -> SERVE -> PLAY
        release_launch(); check_eq("menu_to_set", int'(state), 1);
        release_launch(); check_eq("set_to_serve", int'(state), 2);
        check_eq("serve_ball_reset", int'(ball_reset), 1);
        release_launch(); check_eq("serve_to_play", int'(state), 3);
        check_eq("play_ball_run", int'(ball_run), 1);
        check_eq("play_ball_reset", int'(ball_reset), 0);
        check_eq("play_score_l", int'(score_l), 0);
        check_eq("play_score_r", int'(score_r), 0);
        release_launch(); check_eq("lrel_ignored_play", int'(state), 3);

        // Left goal: right player scores
        left_hit = 1'b1; step(); left_hit = 1'b0;
        check_eq("lhit_state", int'(state), 4);
        check_eq("lhit_score_r", int'(score_r), 1);
        check_eq("lhit_serve_dir", int'(serve_dir), 0);
        check_eq("point_ball_run", int'(ball_run), 0);
        check_eq("point_ball_reset", int'(ball_reset), 0);
        right_hit = 1'b1; step(); right_hit = 1'b0;
        check_eq("hit_in_point_ignored", int'(score_l), 0);
        tick = 1'b1;
        repeat (59) step();
        check_eq("point_59_ticks", int'(state), 4);
        step();
        tick = 1'b0;
        check_eq("point_60_ticks", int'(state), 2);
        check_eq("serve_again_ball_reset", int'(ball_reset), 1);

        // SERVE with ticks only
        tick = 1'b1;
        repeat (89) step();
        check_eq("serve_89_ticks", int'(state), 2);
        step();
        tick = 1'b0;
`ifdef AUTO_SERVE_EN
        check_eq("serve_90_ticks", int'(state), 3);
`else
        check_eq("serve_90_ticks", int'(state), 2);
        release_launch();
        check_eq("serve_release", int'(state), 3);
`endif

        // Simultaneous hits
        left_hit = 1'b1; right_hit = 1'b1; step(); left_hit = 1'b0; right_hit = 1'b0;
        check_eq("both_state", int'(state), 4);
        check_eq("both_score_l", int'(score_l), 0);
        check_eq("both_score_r", int'(score_r), 1);
        check_eq("both_serve_dir", int'(serve_dir), 0);
        hold_point();
        check_eq("both_back_serve", int'(state), 2);

        // Left player wins with five points
        for (int k = 1; k <= 5; k++) begin
            release_launch();
            check_eq("win_serve_to_play", int'(state), 3);
            right_hit = 1'b1; step(); right_hit = 1'b0;
            check_eq("win_score_l", int'(score_l), k);
            check_eq("win_serve_dir", int'(serve_dir), 1);
            hold_point();
            check_eq("win_after_hold", int'(state), (k < 5) ? 2 : 5);
        end
        check_eq("over_winner", int'(winner), 0);
        check_eq("over_ball_reset", int'(ball_reset), 1);
        left_hit = 1'b1; right_hit = 1'b1; step(); step();
        right_hit = 1'b0; step(); left_hit = 1'b0;
        check_eq("over_hits_score_l", int'(score_l), 5);
        check_eq("over_hits_score_r", int'(score_r), 1);
        check_eq("over_hits_state", int'(state), 5);
        release_launch();
        check_eq("over_to_menu", int'(state), 0);
        check_eq("menu_held_score_l", int'(score_l), 5);
        release_launch();
        check_eq("menu_exit_state", int'(state), 1);
        check_eq("menu_exit_score_l", int'(score_l), 0);
        check_eq("menu_exit_score_r", int'(score_r), 0);
        check_eq("menu_exit_serve_dir", int'(serve_dir), 1);

        // Reset mid-PLAY
        release_launch(); release_launch();
        check_eq("pre_rst_play", int'(state), 3);
        reset = 1'b1; step(); reset = 1'b0;
        check_reset_outputs("rst_play");

        // Reset mid-POINT
        release_launch(); release_launch(); release_launch();
        left_hit = 1'b1; step(); left_hit = 1'b0;
        check_eq("pre_rst_point", int'(state), 4);
        tick = 1'b1; repeat (10) step(); tick = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        check_reset_outputs("rst_point");

        // Launch held through reset, seen high once after release
        launch = 1'b1; reset = 1'b1; step(); reset = 1'b0;
        step();
        launch = 1'b0; step();
        check_eq("held_then_release", int'(state), 1);

        // Launch held through reset, dropped on the release cycle
        launch = 1'b1; reset = 1'b1; step();
        reset = 1'b0; launch = 1'b0; step();
        check_eq("held_no_event", int'(state), 0);
        step();
        check_eq("held_no_event_later", int'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
